serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/adder_chunk.sv | 27 ++
 rtl/serial_adder.sv | 104 ++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - state encoding and sizing helper for the digit-serial adder
package serial_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Chunk counter width; a single-chunk adder still needs a 1-bit counter.
  function automatic int cnt_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - combinational DIGIT-bit ripple adder slice
module adder_chunk #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic c;

  always_comb begin
    c    = cin;
    sum  = '0;
    cmsb = cin;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) cmsb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial add/subtract unit, LSB chunk first
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o,
  output logic             c_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int NCHUNK = WIDTH / DIGIT;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] chunk_a;
  logic [DIGIT-1:0] chunk_b;
  logic [DIGIT-1:0] chunk_sum;
  logic             chunk_cout;
  logic             chunk_cmsb;

  // The partial result is assembled in place so the final edge can publish it directly.
  always_comb begin
    chunk_a  = a_q[int'(cnt) * DIGIT +: DIGIT];
    chunk_b  = b_q[int'(cnt) * DIGIT +: DIGIT];
    acc_next = acc;
    acc_next[int'(cnt) * DIGIT +: DIGIT] = chunk_sum;
  end

  adder_chunk #(.DIGIT(DIGIT)) u_chunk (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout),
    .cmsb (chunk_cmsb)
  );

  assign busy_o = (state == S_RUN);
  assign done_o = (state == S_DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      res_o   <= '0;
      c_o     <= 1'b0;
      ovf_o   <= 1'b0;
      zero_o  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          acc     <= acc_next;
          carry_q <= chunk_cout;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= S_DONE;
            res_o  <= acc_next;
            c_o    <= chunk_cout;
            ovf_o  <= chunk_cmsb ^ chunk_cout;
            zero_o <= (acc_next == '0);
          end
        end
        default: begin
          // Subtraction is A + ~B + 1; the incoming carry is replaced by the +1.
          if (start_i) begin
            state   <= S_RUN;
            a_q     <= a_i;
            b_q     <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i ? 1'b1 : c_i;
            cnt     <= '0;
            acc     <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
